rr_burst_arbiter: RTL and testbench

- Parametrised N-channel successor to the two-channel arbiter in the TDC readout path.
- Grants one requesting channel at a time using round-robin priority. Forwards that channel's enable-framed data burst onto a single registered output stream.
- Adds channel-index tagging, a burst-length cap with truncation flag, and a grant timeout.
- Sits between the per-channel TDC FIFO readers and the shared upload/packet builder.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_burst_arbiter_pick.sv | 34 +++
 rtl/rr_burst_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and width helpers for the round-robin burst arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0, callers clamp where a zero width is illegal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Round-robin winner select: first requester at or after ptr, wrapping
// NUM-1 -> 0. The request vector is doubled so the wrap becomes a plain
// lowest-set-bit search over bits at or above ptr.
module rr_pick #(
  parameter int NUM  = 4,
  parameter int CH_W = 2
) (
  input  logic [NUM-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NUM-1:0]  win_oh,
  output logic [CH_W-1:0] win_idx,
  output logic            any
);

  logic [2*NUM-1:0] dbl;
  logic [2*NUM-1:0] masked;
  int               hit;

  // Mask off bits below the pointer, then priority-encode the lowest survivor.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    hit    = 0;
    for (int i = 0; i < 2*NUM; i++)
      masked[i] = dbl[i] & (i >= int'(ptr));
    for (int i = 2*NUM-1; i >= 0; i--)
      if (masked[i]) hit = i;
    win_idx = (hit >= NUM) ? CH_W'(hit - NUM) : CH_W'(hit);
    any     = |req;
    win_oh  = '0;
    if (any) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-channel round-robin burst arbiter. Grants one channel at a time,
// forwards its i_en-framed burst through a two-stage output path (one
// stage of lookahead so o_last lands on the final beat), caps bursts at
// MAX_BURST and revokes grants that never start within GRANT_TIMEOUT.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM           = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 256,
  parameter int GRANT_TIMEOUT = 16,
  localparam int CH_W = (clog2(NUM) < 1) ? 1 : clog2(NUM),
  localparam int BC_W = clog2(MAX_BURST + 1),
  localparam int TO_W = clog2(GRANT_TIMEOUT + 1)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rstn,
  input  logic [NUM-1:0]            i_req,
  output logic [NUM-1:0]            o_grant,
  input  logic [NUM-1:0]            i_en,
  input  logic [NUM*DATA_WIDTH-1:0] i_data,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [CH_W-1:0]           o_chan,
  output logic                      o_last,
  output logic                      o_trunc,
  output logic                      o_timeout
);

  // A one-beat cap means the very first beat already ends the burst.
  localparam logic CAP_ONE = (MAX_BURST == 1);

  arb_state_e state;

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gidx;
  logic [CH_W-1:0] ptr_nxt;
  logic [BC_W-1:0] bcnt;
  logic [BC_W-1:0] bcnt_inc;
  logic [TO_W-1:0] tcnt;
  logic [TO_W-1:0] tcnt_inc;

  // Lookahead stage: holds the newest beat until we know whether it is last.
  logic                  s1_vld;
  logic                  s1_trunc;
  logic [DATA_WIDTH-1:0] s1_data;

  logic [NUM-1:0][DATA_WIDTH-1:0] lane_data;
  logic                  en_g;
  logic                  req_g;
  logic [DATA_WIDTH-1:0] data_g;

  logic [NUM-1:0]  pick_oh;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;

  rr_pick #(
    .NUM  (NUM),
    .CH_W (CH_W)
  ) u_pick (
    .req     (i_req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Only the granted lane is ever looked at; other lanes never reach the output.
  always_comb begin
    lane_data = i_data;
    en_g      = i_en[gidx];
    req_g     = i_req[gidx];
    data_g    = lane_data[gidx];
    ptr_nxt   = (gidx == CH_W'(NUM - 1)) ? '0 : gidx + 1'b1;
    bcnt_inc  = bcnt + 1'b1;
    tcnt_inc  = tcnt + 1'b1;
  end

  // Arbitration FSM with registered grant and output stream.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      s1_vld    <= 1'b0;
      s1_trunc  <= 1'b0;
      s1_data   <= '0;
      o_grant   <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_chan    <= '0;
      o_last    <= 1'b0;
      o_trunc   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_chan    <= '0;
      o_last    <= 1'b0;
      o_trunc   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            o_grant <= pick_oh;
            gidx    <= pick_idx;
            bcnt    <= '0;
            tcnt    <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (en_g) begin
            s1_vld  <= 1'b1;
            s1_data <= data_g;
            bcnt    <= BC_W'(1);
            if (CAP_ONE) begin
              s1_trunc <= 1'b1;
              o_grant  <= '0;
              ptr      <= ptr_nxt;
              state    <= DRAIN;
            end else begin
              s1_trunc <= 1'b0;
              state    <= XFER;
            end
          end else if (!req_g) begin
            // Requester gave up before its first beat: quiet release.
            o_grant <= '0;
            ptr     <= ptr_nxt;
            state   <= IDLE;
          end else if (tcnt_inc == TO_W'(GRANT_TIMEOUT)) begin
            o_grant   <= '0;
            o_timeout <= 1'b1;
            ptr       <= ptr_nxt;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        XFER: begin
          // The held beat goes out now; its last flag depends on this cycle's i_en.
          o_valid <= 1'b1;
          o_data  <= s1_data;
          o_chan  <= gidx;
          if (en_g) begin
            s1_data <= data_g;
            bcnt    <= bcnt_inc;
            if (bcnt_inc == BC_W'(MAX_BURST)) begin
              s1_trunc <= 1'b1;
              o_grant  <= '0;
              ptr      <= ptr_nxt;
              state    <= DRAIN;
            end
          end else begin
            o_last  <= 1'b1;
            s1_vld  <= 1'b0;
            o_grant <= '0;
            ptr     <= ptr_nxt;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // Only a capped burst still has its final beat in the lookahead stage.
          if (s1_vld) begin
            o_valid <= 1'b1;
            o_data  <= s1_data;
            o_chan  <= gidx;
            o_last  <= 1'b1;
            o_trunc <= s1_trunc;
          end
          s1_vld   <= 1'b0;
          s1_trunc <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: NUM=4, MAX_BURST=8, GRANT_TIMEOUT=16.
module tb_rr_burst_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rstn;
  logic [NUM-1:0]  i_req;
  logic [NUM-1:0]  o_grant;
  logic [NUM-1:0]  i_en;
  logic [NUM*DW-1:0] i_data;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [1:0]      o_chan;
  logic            o_last;
  logic            o_trunc;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Beat log filled by the monitor.
  logic [DW-1:0] q_data[$];
  int            q_chan[$];
  bit            q_last[$];
  bit            q_trunc[$];
  int            q_cyc[$];
  int            n_timeout = 0;
  int            n_dead    = 0;

  rr_burst_arbiter #(
    .NUM(NUM), .DATA_WIDTH(DW), .MAX_BURST(8), .GRANT_TIMEOUT(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .i_req(i_req), .o_grant(o_grant),
    .i_en(i_en), .i_data(i_data), .o_valid(o_valid), .o_data(o_data),
    .o_chan(o_chan), .o_last(o_last), .o_trunc(o_trunc), .o_timeout(o_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (sys_rstn) begin
      if (o_valid) begin
        q_data.push_back(o_data);
        q_chan.push_back(int'(o_chan));
        q_last.push_back(o_last);
        q_trunc.push_back(o_trunc);
        q_cyc.push_back(cyc);
        if (o_data == 32'h0000DEAD) n_dead = n_dead + 1;
      end
      if (o_timeout) n_timeout = n_timeout + 1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rstn = 1'b0;
    i_req    = '0;
    i_en     = '0;
    i_data   = '0;
    repeat (2) tick();
    sys_rstn = 1'b1;
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    i_req = '0; i_en = '0; i_data = '0;
    #3;
    checks++;
    if ({o_grant, o_valid, o_data, o_chan, o_last, o_trunc, o_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b valid=%b data=%h", o_grant, o_valid, o_data);
    end
    repeat (2) tick();
    sys_rstn = 1'b1;
    tick();
    checks++;
    if (o_grant !== 4'b0000 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got grant=%b valid=%b exp 0000/0", o_grant, o_valid);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp;
    int qs;
    do_reset();
    qs = q_data.size();
    i_req = 4'b0100;
    tick();
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b exp 0100", o_grant);
    end
    i_en[2] = 1'b1; i_data[2*DW +: DW] = 32'hA0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency got valid=%b exp 0", o_valid);
    end
    for (int k = 1; k < 5; k++) begin
      i_data[2*DW +: DW] = 32'hA0 + 32'(k);
      tick();
      exp = 32'hA0 + 32'(k - 1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp || o_chan !== 2'd2 || o_last !== 1'b0) begin
        errors++;
        $display("FAIL single_beat%0d got v=%b d=%h c=%0d l=%b exp 1/%h/2/0", k-1, o_valid, o_data, o_chan, o_last, exp);
      end
    end
    i_en = '0; i_req = '0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hA4 || o_last !== 1'b1 || o_trunc !== 1'b0 || o_grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_last got v=%b d=%h l=%b t=%b g=%b exp 1/a4/1/0/0000", o_valid, o_data, o_last, o_trunc, o_grant);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got valid=%b exp 0", o_valid);
    end
    tick();
    checks++;
    if (q_data.size() - qs !== 5) begin
      errors++; $display("FAIL single_count got %0d exp 5", q_data.size() - qs);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int order[5];
    int qs;
    int g;
    int w;
    logic [DW-1:0] exp;
    do_reset();
    qs = q_data.size();
    i_req = 4'hF;
    for (int b = 0; b < 5; b++) begin
      g = -1; w = 0;
      while (g < 0 && w < 30) begin
        tick(); w++;
        for (int c = 0; c < NUM; c++) if (o_grant[c]) g = c;
      end
      if (g < 0) begin
        checks++; errors++;
        $display("FAIL rr_wait_grant burst %0d got none exp grant within 30 cycles", b);
        g = exp_order[b];
      end
      order[b] = g;
      for (int k = 0; k < 2; k++) begin
        i_en[g] = 1'b1;
        i_data[g*DW +: DW] = 32'hB0 + 32'(g*16 + k);
        tick();
      end
      i_en[g] = 1'b0;
      if (b == 4) i_req = '0;
    end
    repeat (4) tick();
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (order[b] !== exp_order[b]) begin
        errors++; $display("FAIL rr_order burst %0d got %0d exp %0d", b, order[b], exp_order[b]);
      end
    end
    checks++;
    if (q_data.size() - qs !== 10) begin
      errors++; $display("FAIL rr_beat_count got %0d exp 10", q_data.size() - qs);
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp = 32'hB0 + 32'(exp_order[i/2]*16 + i%2);
        checks++;
        if (q_data[qs+i] !== exp || q_chan[qs+i] !== exp_order[i/2] || q_last[qs+i] !== (i%2 == 1)) begin
          errors++;
          $display("FAIL rr_beat%0d got d=%h c=%0d l=%b exp %h/%0d/%b", i, q_data[qs+i], q_chan[qs+i], q_last[qs+i], exp, exp_order[i/2], (i%2 == 1));
        end
      end
      for (int b = 1; b < 5; b++) begin
        checks++;
        if (q_cyc[qs+2*b] - q_cyc[qs+2*b-1] < 2) begin
          errors++;
          $display("FAIL rr_idle_gap burst %0d got gap %0d exp >=2", b, q_cyc[qs+2*b] - q_cyc[qs+2*b-1]);
        end
      end
    end
  endtask

  task automatic test_truncation();
    logic [NUM-1:0] glog[13];
    logic [DW-1:0] exp;
    int qs;
    int ts;
    do_reset();
    qs = q_data.size();
    ts = n_timeout;
    i_req = 4'b0110;
    tick();
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++; $display("FAIL trunc_grant got %b exp 0010", o_grant);
    end
    for (int k = 0; k < 12; k++) begin
      i_en[1] = 1'b1;
      i_data[1*DW +: DW] = 32'hC0 + 32'(k);
      tick();
      glog[k+1] = o_grant;
    end
    i_en = '0; i_req = '0;
    repeat (4) tick();
    checks++;
    if (glog[7] !== 4'b0010 || glog[8] !== 4'b0000 || glog[10] !== 4'b0100) begin
      errors++;
      $display("FAIL trunc_grant_seq got %b/%b/%b exp 0010/0000/0100", glog[7], glog[8], glog[10]);
    end
    checks++;
    if (q_data.size() - qs !== 8) begin
      errors++; $display("FAIL trunc_count got %0d exp 8", q_data.size() - qs);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = 32'hC0 + 32'(i);
        checks++;
        if (q_data[qs+i] !== exp || q_chan[qs+i] !== 1 || q_last[qs+i] !== (i == 7) || q_trunc[qs+i] !== (i == 7)) begin
          errors++;
          $display("FAIL trunc_beat%0d got d=%h c=%0d l=%b t=%b exp %h/1/%b/%b", i, q_data[qs+i], q_chan[qs+i], q_last[qs+i], q_trunc[qs+i], exp, (i == 7), (i == 7));
        end
      end
    end
    checks++;
    if (n_timeout - ts !== 0) begin
      errors++; $display("FAIL trunc_no_timeout got %0d exp 0", n_timeout - ts);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int qs;
    int ts;
    do_reset();
    qs = q_data.size();
    ts = n_timeout;
    i_req = 4'b1000;
    tick();
    checks++;
    if (o_grant !== 4'b1000) begin
      errors++; $display("FAIL timeout_grant got %b exp 1000", o_grant);
    end
    i_req[0] = 1'b1;
    ok = 1'b1;
    for (int t = 2; t <= 16; t++) begin
      tick();
      if (o_timeout !== 1'b0 || o_grant !== 4'b1000) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL timeout_early got ok=%b exp 1", ok);
    end
    tick();
    checks++;
    if (o_timeout !== 1'b1 || o_grant !== 4'b0000) begin
      errors++; $display("FAIL timeout_pulse got to=%b g=%b exp 1/0000", o_timeout, o_grant);
    end
    tick();
    checks++;
    if (o_timeout !== 1'b0 || o_grant !== 4'b0001) begin
      errors++; $display("FAIL timeout_next got to=%b g=%b exp 0/0001", o_timeout, o_grant);
    end
    i_req = '0;
    repeat (3) tick();
    checks++;
    if (q_data.size() - qs !== 0 || n_timeout - ts !== 1) begin
      errors++;
      $display("FAIL timeout_totals got beats=%0d pulses=%0d exp 0/1", q_data.size() - qs, n_timeout - ts);
    end
  endtask

  task automatic test_interference();
    logic [DW-1:0] exp;
    int qs;
    int ds;
    do_reset();
    qs = q_data.size();
    ds = n_dead;
    i_req = 4'b0001;
    tick();
    for (int k = 0; k < 4; k++) begin
      i_en[0] = 1'b1;
      i_data[0 +: DW] = 32'hD0 + 32'(k);
      i_en[1] = (k % 2 == 0);
      i_data[1*DW +: DW] = 32'h0000DEAD;
      tick();
    end
    i_en = '0; i_req = '0;
    repeat (4) tick();
    checks++;
    if (n_dead - ds !== 0) begin
      errors++; $display("FAIL interf_dead got %0d exp 0", n_dead - ds);
    end
    checks++;
    if (q_data.size() - qs !== 4) begin
      errors++; $display("FAIL interf_count got %0d exp 4", q_data.size() - qs);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 32'hD0 + 32'(i);
        checks++;
        if (q_data[qs+i] !== exp || q_chan[qs+i] !== 0) begin
          errors++;
          $display("FAIL interf_beat%0d got d=%h c=%0d exp %h/0", i, q_data[qs+i], q_chan[qs+i], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    i_req = 4'b0100;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_en[2] = 1'b1;
      i_data[2*DW +: DW] = 32'hE0 + 32'(k);
      tick();
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hE1) begin
      errors++; $display("FAIL midrst_pre got v=%b d=%h exp 1/e1", o_valid, o_data);
    end
    #2 sys_rstn = 1'b0;
    #1;
    checks++;
    if ({o_grant, o_valid, o_data, o_chan, o_last, o_trunc, o_timeout} !== '0) begin
      errors++;
      $display("FAIL midrst_clear got g=%b v=%b d=%h l=%b", o_grant, o_valid, o_data, o_last);
    end
    tick();
    i_en = '0;
    i_req = 4'hF;
    sys_rstn = 1'b1;
    tick();
    checks++;
    if (o_grant !== 4'b0001 || o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_regrant got g=%b v=%b exp 0001/0", o_grant, o_valid);
    end
    i_req = '0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rstn = 1'b0;
    i_req = '0; i_en = '0; i_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_timeout();
    test_interference();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
